lock_display_controller: RTL

Parametrised display controller for the digital lock; drives all seven-segment displays from lock status. It renders passcode entry with a blinking cursor and optional digit masking, shows a timed error message, and shows a persistent unlock message. Hex-coded frame is registered, then converted by an internal HexTo7SegmentNBit instance (DISPLAYS digits). It sits between the lock FSM and the board displays.

---
 rtl/lock_display_controller.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/lock_display_controller.sv
// Display controller for the digital lock: renders passcode entry with a blinking cursor,
// a timed error frame and a persistent unlock frame, and drives the seven-segment digits.

module HexTo7SegmentNBit #(
  parameter int DIGITS = 1
) (
  input  logic [4*DIGITS-1:0] hex_i,
  output logic [8*DIGITS-1:0] seg_o
);

  // Active-low gfedcba segments; bit 7 is the decimal point, held off.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    assign seg_o[8*g+:8] = {1'b1, ~hex_to_seg(hex_i[4*g+:4])};
  end

endmodule

// state       | meaning
// ST_ENTRY    | passcode entry frame with blinking cursor
// ST_ERROR    | error frame held for ERROR_CYCLES cycles
// ST_UNLOCKED | unlock frame held until relock
module lock_display_controller #(
  parameter int PASSCODE_LENGTH = 4,
  parameter int PASSCODE_WIDTH = 4*PASSCODE_LENGTH,
  parameter int DISPLAYS = 6,
  parameter int BLINK_CYCLES = 25000000,
  parameter int ERROR_CYCLES = 50000000,
  parameter bit MASK_ENTRY = 1'b0,
  parameter logic [3:0] BLANK_CODE = 4'hE,
  parameter logic [3:0] CURSOR_CODE = 4'hF,
  parameter logic [3:0] MASK_CODE = 4'h8,
  parameter logic [4*DISPLAYS-1:0] ERROR_MSG = 24'hFCDDED,
  parameter logic [4*DISPLAYS-1:0] UNLOCK_MSG = 24'hEE0A0A
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 error,
  input  logic                                 unlock,
  input  logic                                 relock,
  input  logic [$clog2(PASSCODE_LENGTH+1)-1:0] digitCount,
  input  logic [PASSCODE_WIDTH-1:0]            userEntry,
  output logic [4*DISPLAYS-1:0]                hexDigits,
  output logic [8*DISPLAYS-1:0]                displays,
  output logic                                 messageActive
);

  localparam int CNT_W   = $clog2(PASSCODE_LENGTH+1);
  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int TIMER_W = (ERROR_CYCLES > 1) ? $clog2(ERROR_CYCLES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ERROR_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LEN        = CNT_W'(PASSCODE_LENGTH);

  typedef enum logic [1:0] {
    ST_ENTRY    = 2'd0,
    ST_ERROR    = 2'd1,
    ST_UNLOCKED = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [BLINK_W-1:0]   blink_q, blink_d;
  logic                 cursor_q, cursor_d;
  logic [CNT_W-1:0]     count_prev_q;
  logic [4*DISPLAYS-1:0] hex_q, hex_d;
  logic                 active_q, active_d;

  logic [CNT_W-1:0]      count_eff;
  logic [31:0]           count_eff_w;
  logic [4*DISPLAYS-1:0] entry_frame;
  logic                  count_changed;

  assign count_eff     = (digitCount > LEN) ? LEN : digitCount;
  assign count_eff_w   = 32'(count_eff);
  assign count_changed = (digitCount != count_prev_q);

  // Timer loads ERROR_CYCLES-1 so the frame is held exactly ERROR_CYCLES cycles.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ST_ENTRY: begin
        if (error) begin
          state_d = ST_ERROR;
          timer_d = TIMER_LAST;
        end else if (unlock) begin
          state_d = ST_UNLOCKED;
        end
      end
      ST_ERROR: begin
        if (error) begin
          timer_d = TIMER_LAST;
        end else if (timer_q == '0) begin
          state_d = ST_ENTRY;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_UNLOCKED: begin
        if (relock) state_d = ST_ENTRY;
      end
      default: state_d = ST_ENTRY;
    endcase
  end

  // Blink restarts whenever entry begins or the digit count moves.
  always_comb begin
    blink_d  = blink_q;
    cursor_d = cursor_q;
    if (state_q != ST_ENTRY || state_d != ST_ENTRY || count_changed) begin
      blink_d  = '0;
      cursor_d = 1'b1;
    end else if (blink_q == BLINK_LAST) begin
      blink_d  = '0;
      cursor_d = ~cursor_q;
    end else begin
      blink_d = blink_q + 1'b1;
    end
  end

  for (genvar g = 0; g < DISPLAYS; g++) begin : g_digit
    localparam logic [31:0] IDX = g;
    if (g < PASSCODE_LENGTH) begin : g_code
      assign entry_frame[4*g+:4] =
        (IDX < count_eff_w) ? (MASK_ENTRY ? MASK_CODE : userEntry[4*g+:4]) :
        (IDX == count_eff_w && count_eff < LEN) ? (cursor_d ? CURSOR_CODE : BLANK_CODE) :
        BLANK_CODE;
    end else begin : g_blank
      assign entry_frame[4*g+:4] = BLANK_CODE;
    end
  end

  always_comb begin
    hex_d    = entry_frame;
    active_d = (state_d != ST_ENTRY);
    case (state_d)
      ST_ERROR:    hex_d = ERROR_MSG;
      ST_UNLOCKED: hex_d = UNLOCK_MSG;
      default:     hex_d = entry_frame;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_ENTRY;
      timer_q      <= '0;
      blink_q      <= '0;
      cursor_q     <= 1'b1;
      count_prev_q <= '0;
      hex_q        <= {DISPLAYS{BLANK_CODE}};
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      blink_q      <= blink_d;
      cursor_q     <= cursor_d;
      count_prev_q <= digitCount;
      hex_q        <= hex_d;
      active_q     <= active_d;
    end
  end

  assign hexDigits     = hex_q;
  assign messageActive = active_q;

  HexTo7SegmentNBit #(
    .DIGITS(DISPLAYS)
  ) u_hex_to_seg (
    .hex_i(hex_q),
    .seg_o(displays)
  );

endmodule
